// File: rtl/ifc_or_arbiter_pkg.sv
// Shared types and constants for the round-robin or-gate arbiter.
// Timeout width applies only when IFC_OR_ARB_TIMEOUT_EN is defined.
package ifc_or_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  localparam int NUM_REQ_MAX = 8;
  localparam int TMO_W       = 16;

endpackage

// File: rtl/ifc_or_arbiter_if.sv
// Client and gate side signals of the arbiter.
// slave is the arbiter view, master is the client/gate view.
interface ifc_or_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0] req_en;
  logic [NUM_REQ-1:0] req_a;
  logic [NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0] req_rdy;
  logic [NUM_REQ-1:0] rsp_en;
  logic [NUM_REQ-1:0] rsp_rdy;
  logic [NUM_REQ-1:0] rsp_data;

  logic gate_a_data;
  logic gate_a_en;
  logic gate_a_rdy;
  logic gate_b_data;
  logic gate_b_en;
  logic gate_b_rdy;
  logic gate_y_en;
  logic gate_y_data;
  logic gate_y_rdy;
  logic busy;
  logic err;

  modport slave (
    input  req_en, req_a, req_b, rsp_en,
    input  gate_a_rdy, gate_b_rdy,
    input  gate_y_data, gate_y_rdy,
    output req_rdy, rsp_rdy, rsp_data,
    output gate_a_data, gate_a_en,
    output gate_b_data, gate_b_en,
    output gate_y_en, busy, err
  );

  modport master (
    output req_en, req_a, req_b, rsp_en,
    output gate_a_rdy, gate_b_rdy,
    output gate_y_data, gate_y_rdy,
    input  req_rdy, rsp_rdy, rsp_data,
    input  gate_a_data, gate_a_en,
    input  gate_b_data, gate_b_en,
    input  gate_y_en, busy, err
  );

endinterface

// File: rtl/ifc_or_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible
// index strictly after ptr, wrapping around.
module ifc_rr_pick
  import ifc_or_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] j;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!valid && elig[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/ifc_or_arbiter.sv
// Round-robin sharing of one or-gate among NUM_REQ clients.
// Define IFC_OR_ARB_TIMEOUT_EN to enable the gate watchdog.
module ifc_or_arbiter
  import ifc_or_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic CLK,
  input logic RST_N,
  ifc_or_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t state, state_nx;

  logic [IW-1:0]      ptr, gnt, pick;
  logic               pick_vld;
  logic [NUM_REQ-1:0] req_full, req_aq, req_bq;
  logic [NUM_REQ-1:0] rsp_full, rsp_q, elig;
  logic               wa, wb, a_sent, b_sent;
  logic               a_en, b_en, y_en;
  logic               a_data, b_data;
  logic               tmo, err_q;

  // A full response slot blocks its owner so results always have a home
  assign elig = req_full & ~rsp_full;

  ifc_rr_pick #(.N(NUM_REQ)) u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .idx   (pick),
    .valid (pick_vld)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    a_en     = 1'b0;
    b_en     = 1'b0;
    y_en     = 1'b0;
    a_data   = 1'b0;
    b_data   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_vld) state_nx = ISSUE;
      end
      ISSUE: begin
        a_en   = !a_sent && bus.gate_a_rdy;
        b_en   = !b_sent && bus.gate_b_rdy;
        a_data = wa;
        b_data = wb;
        if ((a_sent || a_en) && (b_sent || b_en))
          state_nx = WAIT;
      end
      WAIT: begin
        y_en = bus.gate_y_rdy;
        if (y_en) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (tmo) state_nx = IDLE;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr      <= IW'(NUM_REQ - 1);
      gnt      <= '0;
      req_full <= '0;
      req_aq   <= '0;
      req_bq   <= '0;
      rsp_full <= '0;
      rsp_q    <= '0;
      wa       <= 1'b0;
      wb       <= 1'b0;
      a_sent   <= 1'b0;
      b_sent   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_en[i] && !req_full[i]) begin
          req_full[i] <= 1'b1;
          req_aq[i]   <= bus.req_a[i];
          req_bq[i]   <= bus.req_b[i];
        end
        if (bus.rsp_en[i] && rsp_full[i]) begin
          rsp_full[i] <= 1'b0;
          rsp_q[i]    <= 1'b0;
        end
      end
      if (state == IDLE && pick_vld) begin
        gnt            <= pick;
        ptr            <= pick;
        wa             <= req_aq[pick];
        wb             <= req_bq[pick];
        req_full[pick] <= 1'b0;
        a_sent         <= 1'b0;
        b_sent         <= 1'b0;
      end
      if (a_en) a_sent <= 1'b1;
      if (b_en) b_sent <= 1'b1;
      if (y_en) begin
        rsp_full[gnt] <= 1'b1;
        rsp_q[gnt]    <= bus.gate_y_data;
        a_sent        <= 1'b0;
        b_sent        <= 1'b0;
      end else if (tmo) begin
        rsp_full[gnt] <= 1'b1;
        rsp_q[gnt]    <= 1'b0;
        a_sent        <= 1'b0;
        b_sent        <= 1'b0;
      end
    end
  end

`ifdef IFC_OR_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] cnt;

  // A completing y handshake wins over the watchdog
  assign tmo = (state != IDLE)
            && (cnt == TMO_W'(TIMEOUT_CYCLES - 1))
            && !(state == WAIT && bus.gate_y_rdy);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE) cnt <= '0;
      else               cnt <= cnt + 1'b1;
      if (tmo) err_q <= 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign tmo        = 1'b0;
  assign err_q      = 1'b0;
`endif

  assign bus.req_rdy     = ~req_full;
  assign bus.rsp_rdy     = rsp_full;
  assign bus.rsp_data    = rsp_q;
  assign bus.gate_a_en   = a_en;
  assign bus.gate_b_en   = b_en;
  assign bus.gate_y_en   = y_en;
  assign bus.gate_a_data = a_data;
  assign bus.gate_b_data = b_data;
  assign bus.busy        = (state != IDLE);
  assign bus.err         = err_q;

endmodule
